// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-port bus; master = CPU, slave = console peripheral
//   addr/wdata/we/re : byte address, store data, one-cycle store/load strobes
//   rdata            : load data, valid the cycle after re
//   sel              : peripheral decodes addr into its 16-byte window
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        sel;
  modport master (output addr, wdata, we, re, input rdata, sel);
  modport slave (input addr, wdata, we, re, output rdata, sel);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped console (FIFO-buffered 8N1 UART transmitter) plus halt/exit register
//   clk, reset  : clock, synchronous active-high reset
//   bus         : slave side of the CPU data-port bus (TXDATA 0x0, STATUS 0x4, HALT 0x8)
//   txd_o       : registered UART serial output, idle high
//   halt_o      : sticky, set by any HALT write
//   exit_code_o : last value written to HALT
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          txd_o,
  output logic          halt_o,
  output logic [31:0]   exit_code_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic txd_q, txd_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic ovf_q, halt_q;
  logic [31:0] exit_q, rdata_q;
  logic full, empty, pop, push_req, push, tick, wr_stat, wr_halt;
  logic [1:0] off;
  logic unused_lsb;
  assign unused_lsb = ^bus.addr[1:0];
  assign bus.sel = bus.addr[31:4] == BASE_ADDR[31:4];
  assign off = bus.addr[3:2];
  // pointers carry one extra wrap bit: equal -> empty, differ only in wrap bit -> full
  assign empty = wp_q == rp_q;
  assign full = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
  assign pop = state_q == IDLE && !empty;
  assign push_req = bus.sel && bus.we && off == 2'd0;
  // a same-cycle pop frees a slot, so a full FIFO still accepts the byte
  assign push = push_req && (!full || pop);
  assign wr_stat = bus.sel && bus.we && off == 2'd1;
  assign wr_halt = bus.sel && bus.we && off == 2'd2;
  assign tick = cnt_q == CMAX;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      txd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      txd_q <= txd_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (empty ? IDLE : START)
            : !tick ? state_q
            : state_q == START ? DATA
            : state_q == DATA ? (bit_q == 3'd7 ? STOP : DATA)
            : IDLE;
  end
  // txd is computed from the next state so the pin itself comes straight from a flop
  always_comb begin
    cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
    bit_d = state_q != DATA ? 3'd0 : tick ? bit_q + 3'd1 : bit_q;
    sh_d = pop ? mem_q[rp_q[AW-1:0]] : (state_q == DATA && tick) ? {1'b0, sh_q[7:1]} : sh_q;
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= bus.wdata[7:0];
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      ovf_q <= 1'b0;
      halt_q <= 1'b0;
      exit_q <= '0;
      rdata_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + (AW+1)'(1);
      if (pop) rp_q <= rp_q + (AW+1)'(1);
      ovf_q <= (push_req && !push) || (ovf_q && !(wr_stat && bus.wdata[3]));
      if (wr_halt) begin
        halt_q <= 1'b1;
        exit_q <= bus.wdata;
      end
      // read data uses pre-edge state, so a same-cycle write is not visible yet
      if (bus.sel && bus.re)
        rdata_q <= off == 2'd1 ? {28'd0, ovf_q, state_q != IDLE, empty, full}
                 : off == 2'd2 ? exit_q : '0;
    end
  end
  assign bus.rdata = rdata_q;
  assign txd_o = txd_q;
  assign halt_o = halt_q;
  assign exit_code_o = exit_q;
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped console/exit peripheral; the responder on the CPU data-memory bus for stores and loads in its address window.
- Bytes stored by the CPU are buffered in a FIFO and serialized as 8N1 UART on txd.
- A halt register lets a program end simulation with an exit code (e.g. a0 value).
- Sits beside data memory inside CPU's top level; the bench watches txd/halt instead of polling internal signals.

Parameters:
BASE_ADDR, 32'h1000_0000, base of 16-byte register window (addr[31:4] compare)
CLKS_PER_BIT, 16, clk cycles per UART bit (>=2)
FIFO_DEPTH, 8, TX FIFO entries, power of 2 (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
addr  input  32  byte address from CPU data port
wdata  input  32  store data
we  input  1  store strobe, one cycle per store
re  input  1  load strobe, one cycle per load
rdata  output  32  load data, valid the cycle after re
sel  output  1  combinational: addr[31:4]==BASE_ADDR[31:4]
txd  output  1  UART serial out, idle high
halt  output  1  sticky, set by HALT write
exit_code  output  32  value written to HALT

Behaviour:
- Reset (clk edge with reset=1): rdata=0, txd=1, halt=0, exit_code=0, FIFO empty, overflow=0, FSM IDLE, bit/clock counters 0. Reset mid-frame aborts the frame; txd=1 the cycle after.
- Accesses act only when sel=1; out-of-window accesses ignored, rdata unchanged.
- Register map (addr[3:2]; addr[1:0] ignored):
  - 0x0 TXDATA W: push wdata[7:0]. If FIFO full: byte dropped, overflow set. Read returns 0.
  - 0x4 STATUS R: bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 overflow, others 0. Write with wdata[3]=1 clears overflow.
  - 0x8 HALT W: halt<=1, exit_code<=wdata. Later writes update exit_code; halt stays 1 until reset. Read returns exit_code.
  - 0xC reserved: reads 0, writes ignored.
- Read latency 1: re at cycle N -> rdata at N+1, held until next in-window read. STATUS sampled at edge N (before that edge's push/pop).
- Same-cycle we and re: write performed, read returns pre-write state.
- FIFO: circular, wrap-around pointers with extra bit for full/empty. Push and pop in same cycle when full: pop then push, no overflow. When empty: push only, pop deferred.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If FIFO non-empty, pop into shift register, go START. First START cycle is the cycle after the pop edge.
  - START: txd=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles -> STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles -> IDLE.
  - Frame = 10*CLKS_PER_BIT cycles. Back-to-back bytes: one idle cycle between frames (IDLE pop cycle).
- txd driven from a register (glitch-free).
- halt does not stall the transmitter; queued bytes keep draining.

Test Plan:
- CLKS_PER_BIT=4. Store 0x41 to BASE+0 at cycle 0 -> txd low cycles 2-5, bits 1,0,0,0,0,0,1,0 at 4 cycles each, high from cycle 38; STATUS busy=1 during frame, busy=0 and empty=1 after.
- Store 0x48,0x69 on consecutive cycles -> two frames decode "Hi", one idle-high cycle between them, no overflow.
- FIFO_DEPTH=8: 10 back-to-back stores of 0x30..0x39 -> first pops immediately, 8 buffered, 10th dropped; STATUS read shows full=1, overflow=1; serial output 0x30..0x38; write STATUS 0x8 clears overflow.
- Store 0x2A to BASE+8 -> halt=1 and exit_code=42 next cycle; read BASE+8 -> rdata=42 one cycle after re; store 0 -> exit_code=0, halt stays 1.
- Assert reset mid-frame after 3 data bits -> txd=1, FIFO empty, STATUS=0x2 on next read, halt=0.
- Store to BASE+0x10 and read BASE+0xC -> sel=0 and no push for the first; rdata=0 for the second; FIFO unchanged.
